// File: rtl/ws2812_decoder.sv
// WS2812B strand receiver: measures high-pulse widths to recover GRB colour words
// and reports frame boundaries, per-frame overflow and protocol errors.
module ws2812_decoder #(
    parameter int CLOCK_SPEED     = 100_000_000,
    parameter int NUM_LEDS        = 20,
    parameter int COLOR_WIDTH     = 8,
    parameter int BIT_THRESH_NS   = 600,
    parameter int MIN_HIGH_NS     = 150,
    parameter int MAX_HIGH_NS     = 2000,
    parameter int RESET_DETECT_NS = 40_000
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        strand_in,
    output logic [COLOR_WIDTH-1:0]      green_out,
    output logic [COLOR_WIDTH-1:0]      red_out,
    output logic [COLOR_WIDTH-1:0]      blue_out,
    output logic                        color_valid,
    output logic [$clog2(NUM_LEDS)-1:0] led_index,
    output logic                        frame_done,
    output logic                        overflow_out,
    output logic                        error_out
);

    localparam int CYC_PER_US   = CLOCK_SPEED / 1_000_000;
    localparam int BIT_THRESH   = BIT_THRESH_NS * CYC_PER_US / 1000;
    localparam int MIN_HIGH     = MIN_HIGH_NS * CYC_PER_US / 1000;
    localparam int MAX_HIGH     = MAX_HIGH_NS * CYC_PER_US / 1000;
    localparam int RESET_DETECT = RESET_DETECT_NS * CYC_PER_US / 1000;

    localparam int WORD_W = 3 * COLOR_WIDTH;
    localparam int HIGH_W = $clog2(MAX_HIGH + 2);
    localparam int LOW_W  = $clog2(RESET_DETECT + 1);
    localparam int BIT_W  = $clog2(WORD_W);
    localparam int WCNT_W = $clog2(NUM_LEDS + 1);
    localparam int IDX_W  = $clog2(NUM_LEDS);

    localparam logic [HIGH_W-1:0] THRESH_C = HIGH_W'(BIT_THRESH);
    localparam logic [HIGH_W-1:0] MIN_C    = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] MAX_C    = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] HIGH_SAT = HIGH_W'(MAX_HIGH + 1);
    localparam logic [LOW_W-1:0]  LOW_SAT  = LOW_W'(RESET_DETECT);
    localparam logic [LOW_W-1:0]  RESET_M1 = LOW_W'(RESET_DETECT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] NUM_C    = WCNT_W'(NUM_LEDS);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, RESYNC} state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, sync3_q;
    logic [HIGH_W-1:0]      high_cnt_q, high_cnt_d;
    logic [LOW_W-1:0]       low_cnt_q, low_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [WORD_W-2:0]      shift_q, shift_d;
    logic                   ovf_seen_q, ovf_seen_d;
    logic [COLOR_WIDTH-1:0] green_q, green_d, red_q, red_d, blue_q, blue_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic                   valid_q, valid_d, frame_q, frame_d;
    logic                   ovf_q, ovf_d, err_q, err_d;

    logic              rise, fall, reset_det, bit_val;
    logic [WORD_W-1:0] word_full;

    assign rise      = sync2_q & ~sync3_q;
    assign fall      = ~sync2_q & sync3_q;
    assign reset_det = ~sync2_q && (low_cnt_q == RESET_M1);
    assign bit_val   = (high_cnt_q >= THRESH_C);
    assign word_full = {shift_q, bit_val};

    // Pulse-width counters: each clears whenever the line is at the opposite level.
    always_comb begin
        high_cnt_d = '0;
        low_cnt_d  = '0;
        if (sync2_q) begin
            high_cnt_d = (high_cnt_q == HIGH_SAT) ? high_cnt_q : high_cnt_q + HIGH_W'(1);
        end else begin
            low_cnt_d = (low_cnt_q == LOW_SAT) ? low_cnt_q : low_cnt_q + LOW_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        ovf_seen_d = ovf_seen_q;
        green_d    = green_q;
        red_d      = red_q;
        blue_d     = blue_q;
        index_d    = index_q;
        valid_d    = 1'b0;
        frame_d    = 1'b0;
        ovf_d      = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE, LOW: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    if (high_cnt_q < MIN_C) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = RESYNC;
                    end else begin
                        shift_d = word_full[WORD_W-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            state_d   = IDLE;
                            // Words past the frame capacity are dropped; only the first one is flagged.
                            if (word_cnt_q == NUM_C) begin
                                if (!ovf_seen_q) begin
                                    ovf_d      = 1'b1;
                                    ovf_seen_d = 1'b1;
                                end
                            end else begin
                                green_d    = word_full[WORD_W-1 -: COLOR_WIDTH];
                                red_d      = word_full[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
                                blue_d     = word_full[COLOR_WIDTH-1:0];
                                index_d    = word_cnt_q[IDX_W-1:0];
                                valid_d    = 1'b1;
                                word_cnt_d = word_cnt_q + WCNT_W'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            state_d   = LOW;
                        end
                    end
                end else if (sync2_q && high_cnt_q >= MAX_C) begin
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = RESYNC;
                end
            end
            default: ;
        endcase

        if (reset_det && state_q != HIGH) begin
            frame_d    = |word_cnt_q;
            err_d      = |bit_cnt_q;
            word_cnt_d = '0;
            bit_cnt_d  = '0;
            ovf_seen_d = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            ovf_seen_q <= 1'b0;
            green_q    <= '0;
            red_q      <= '0;
            blue_q     <= '0;
            index_q    <= '0;
            valid_q    <= 1'b0;
            frame_q    <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= strand_in;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            ovf_seen_q <= ovf_seen_d;
            green_q    <= green_d;
            red_q      <= red_d;
            blue_q     <= blue_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    assign green_out    = green_q;
    assign red_out      = red_q;
    assign blue_out     = blue_q;
    assign led_index    = index_q;
    assign color_valid  = valid_q;
    assign frame_done   = frame_q;
    assign overflow_out = ovf_q;
    assign error_out    = err_q;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed testbench for ws2812_decoder (NUM_LEDS = 4, 100 MHz timing defaults).
module tb_ws2812_decoder;

    localparam int RESET_CYC = 4100;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       strand_in;
    logic [7:0] green_out, red_out, blue_out;
    logic       color_valid, frame_done, overflow_out, error_out;
    logic [1:0] led_index;

    int assertCount = 0;
    int failCount   = 0;
    int validCount  = 0;
    int frameCount  = 0;
    int ovfCount    = 0;
    int errorCount  = 0;
    int lowCycles   = 0;
    int lastValidLow = -1;
    int lastFrameLow = -1;
    int bValid, bFrame, bOvf, bErr;
    logic [23:0] wordLog[$];
    logic [1:0]  indexLog[$];

    ws2812_decoder #(.NUM_LEDS(4)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .strand_in   (strand_in),
        .green_out   (green_out),
        .red_out     (red_out),
        .blue_out    (blue_out),
        .color_valid (color_valid),
        .led_index   (led_index),
        .frame_done  (frame_done),
        .overflow_out(overflow_out),
        .error_out   (error_out)
    );

    always #5 clk_in = ~clk_in;

    // Length of the current low run on the strand, counted in sampling edges.
    always @(posedge clk_in) lowCycles <= strand_in ? 0 : lowCycles + 1;

    // Record every output pulse away from the active edge so directed steps can inspect them.
    always @(negedge clk_in) begin
        if (color_valid) begin
            validCount++;
            wordLog.push_back({green_out, red_out, blue_out});
            indexLog.push_back(led_index);
            lastValidLow = lowCycles;
        end
        if (frame_done) begin
            frameCount++;
            lastFrameLow = lowCycles;
        end
        if (overflow_out) ovfCount++;
        if (error_out) errorCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] wordAt(input int k);
        return (k < wordLog.size()) ? {8'h00, wordLog[k]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] indexAt(input int k);
        return (k < indexLog.size()) ? {30'h0, indexLog[k]} : 32'hFFFF_FFFF;
    endfunction

    task automatic holdLevel(input logic level, input int cycles);
        strand_in = level;
        repeat (cycles) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic applyStimulus(input int highCycles, input int lowCyc);
        holdLevel(1'b1, highCycles);
        holdLevel(1'b0, lowCyc);
    endtask

    // Gap length is irrelevant to decoding, so both symbols use a 45-cycle low.
    task automatic sendBits(input logic [23:0] word, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            if (word[i]) applyStimulus(80, 45);
            else         applyStimulus(40, 45);
        end
    endtask

    task automatic sendWord(input logic [23:0] word);
        sendBits(word, 23, 0);
    endtask

    task automatic snapshot();
        bValid = validCount;
        bFrame = frameCount;
        bOvf   = ovfCount;
        bErr   = errorCount;
    endtask

    initial begin
        rst_n_in  = 1'b0;
        strand_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("reset colour", {8'h00, green_out, red_out, blue_out}, 32'h0);
        checkOutput("reset flags", {26'h0, color_valid, frame_done, overflow_out, error_out, led_index}, 32'h0);
        rst_n_in = 1'b1;
        holdLevel(1'b0, 10);

        $display("[TB] single word");
        snapshot();
        sendWord(24'hFF0000);
        holdLevel(1'b0, RESET_CYC);
        checkOutput("t1 valid count", validCount - bValid, 1);
        checkOutput("t1 word", wordAt(bValid), 32'hFF0000);
        checkOutput("t1 index", indexAt(bValid), 0);
        checkOutput("t1 valid latency", lastValidLow, 3);
        checkOutput("t1 frame count", frameCount - bFrame, 1);
        checkOutput("t1 frame latency", lastFrameLow, 4002);
        checkOutput("t1 error count", errorCount - bErr, 0);
        checkOutput("t1 held outputs", {8'h00, green_out, red_out, blue_out}, 32'hFF0000);

        $display("[TB] three words");
        snapshot();
        sendWord(24'h123456);
        sendWord(24'hABCDEF);
        sendWord(24'h000001);
        holdLevel(1'b0, RESET_CYC);
        checkOutput("t2 valid count", validCount - bValid, 3);
        checkOutput("t2 word0", wordAt(bValid), 32'h123456);
        checkOutput("t2 word1", wordAt(bValid + 1), 32'hABCDEF);
        checkOutput("t2 word2", wordAt(bValid + 2), 32'h000001);
        checkOutput("t2 index0", indexAt(bValid), 0);
        checkOutput("t2 index1", indexAt(bValid + 1), 1);
        checkOutput("t2 index2", indexAt(bValid + 2), 2);
        checkOutput("t2 frame count", frameCount - bFrame, 1);
        checkOutput("t2 error count", errorCount - bErr, 0);

        $display("[TB] bit thresholds");
        snapshot();
        applyStimulus(59, 45);
        applyStimulus(60, 45);
        applyStimulus(15, 45);
        sendBits(24'h5A5A5A, 20, 0);
        holdLevel(1'b0, RESET_CYC);
        checkOutput("t3 threshold word", wordAt(bValid), 32'h5A5A5A);
        checkOutput("t3 threshold index", indexAt(bValid), 0);
        checkOutput("t3 threshold errors", errorCount - bErr, 0);

        snapshot();
        applyStimulus(14, 45);
        sendWord(24'h00FF00);
        holdLevel(1'b0, RESET_CYC);
        checkOutput("t3 glitch errors", errorCount - bErr, 1);
        checkOutput("t3 glitch valid", validCount - bValid, 0);
        checkOutput("t3 glitch frame", frameCount - bFrame, 0);

        snapshot();
        holdLevel(1'b1, 201);
        holdLevel(1'b0, 5);
        checkOutput("t3 stuck errors", errorCount - bErr, 1);
        holdLevel(1'b0, RESET_CYC);
        checkOutput("t3 stuck valid", validCount - bValid, 0);
        checkOutput("t3 stuck frame", frameCount - bFrame, 0);
        checkOutput("t3 stuck errors after reset", errorCount - bErr, 1);

        $display("[TB] truncated word");
        snapshot();
        sendBits(24'hABCDEF, 23, 14);
        holdLevel(1'b0, RESET_CYC);
        checkOutput("t4 errors", errorCount - bErr, 1);
        checkOutput("t4 frame", frameCount - bFrame, 0);
        checkOutput("t4 valid", validCount - bValid, 0);

        $display("[TB] overflow");
        snapshot();
        sendWord(24'h111111);
        sendWord(24'h222222);
        sendWord(24'h333333);
        sendWord(24'h444444);
        sendWord(24'h555555);
        checkOutput("t5 overflow pulse", ovfCount - bOvf, 1);
        checkOutput("t5 outputs unchanged", {8'h00, green_out, red_out, blue_out}, 32'h444444);
        holdLevel(1'b0, RESET_CYC);
        checkOutput("t5 valid count", validCount - bValid, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t5 index%0d", k), indexAt(bValid + k), k);
        end
        checkOutput("t5 word3", wordAt(bValid + 3), 32'h444444);
        checkOutput("t5 frame count", frameCount - bFrame, 1);
        checkOutput("t5 overflow total", ovfCount - bOvf, 1);
        checkOutput("t5 errors", errorCount - bErr, 0);
        snapshot();
        sendWord(24'hC3C3C3);
        checkOutput("t5 next frame valid", validCount - bValid, 1);
        checkOutput("t5 next frame index", indexAt(bValid), 0);

        $display("[TB] asynchronous reset mid-word");
        sendBits(24'h0F0F0F, 23, 12);
        holdLevel(1'b1, 30);
        rst_n_in = 1'b0;
        #1;
        checkOutput("t6 async colour", {8'h00, green_out, red_out, blue_out}, 32'h0);
        checkOutput("t6 async flags", {26'h0, color_valid, frame_done, overflow_out, error_out, led_index}, 32'h0);
        holdLevel(1'b0, 5);
        rst_n_in = 1'b1;
        holdLevel(1'b0, RESET_CYC);
        snapshot();
        sendWord(24'h0F1E2D);
        holdLevel(1'b0, RESET_CYC);
        checkOutput("t6 valid count", validCount - bValid, 1);
        checkOutput("t6 word", wordAt(bValid), 32'h0F1E2D);
        checkOutput("t6 index", indexAt(bValid), 0);
        checkOutput("t6 errors", errorCount - bErr, 0);
        checkOutput("t6 frame", frameCount - bFrame, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
